// File: rtl/dram_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | dram_arbiter: CPU/debug req-gnt arbiter for the 32x32 data RAM.        |
// | Optional post-reset FILL sweep macro: DRAM_CLEAR_EN.     Rev 1.0       |
// +------------------------------------------------------------------------+
module dram_arbiter #(
  parameter int unsigned       ADDR_W = 5,
  parameter int unsigned       DATA_W = 32,
  parameter logic [DATA_W-1:0] FILL   = 32'hAAAAAAAA,
  parameter int unsigned       RR     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic LAST_CPU = 1'b0;
  localparam logic LAST_DBG = 1'b1;

  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d, dbg_rvalid_q, dbg_rvalid_d;
  logic              run, sweep;
  logic [ADDR_W-1:0] sweep_addr;
  logic              cpu_win, dbg_win;

`ifdef DRAM_CLEAR_EN
  typedef enum logic [0:0] {S_CLEAR = 1'b0, S_RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {ADDR_W{1'b1}}) state_d = S_RUN;
    end
  end

  assign sweep      = (state_q == S_CLEAR) && !rst;
  assign run        = (state_q == S_RUN) && !rst;
  assign sweep_addr = cnt_q;
`else
  assign sweep      = 1'b0;
  assign run        = !rst;
  assign sweep_addr = '0;
`endif

  // Tie with RR: the port that did not win last time; pointer resets to DBG.
  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (run) begin
      if (cpu_req && dbg_req) begin
        if ((RR != 0) && (last_q == LAST_CPU)) dbg_win = 1'b1;
        else                                   cpu_win = 1'b1;
      end else begin
        cpu_win = cpu_req;
        dbg_win = dbg_req;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = cpu_wdata;
    if (sweep) begin
      mem_we    = 1'b1;
      mem_addr  = sweep_addr;
      mem_wdata = FILL;
    end else if (cpu_win) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_win) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  always_comb begin
    last_d       = last_q;
    if (cpu_win)      last_d = LAST_CPU;
    else if (dbg_win) last_d = LAST_DBG;
    cpu_rvalid_d = cpu_win && !cpu_we;
    dbg_rvalid_d = dbg_win && !dbg_we;
    cpu_rdata_d  = cpu_rvalid_d ? mem_rdata : cpu_rdata_q;
    dbg_rdata_d  = dbg_rvalid_d ? mem_rdata : dbg_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q       <= LAST_DBG;
      addr_q       <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      last_q       <= last_d;
      addr_q       <= mem_addr;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  assign cpu_gnt    = cpu_win;
  assign dbg_gnt    = dbg_win;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign busy       = sweep;

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_dram_arbiter: directed + randomized bench for dram_arbiter (RR=1    |
// | instance "a", RR=0 instance "b", shared stimulus).        Rev 1.0      |
// +------------------------------------------------------------------------+
module tb_dram_arbiter;

  localparam logic [31:0] FILL = 32'hAAAAAAAA;

  logic        clk, rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [4:0]  cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata;

  logic        cpu_gnt_a, cpu_rvalid_a, dbg_gnt_a, dbg_rvalid_a, mem_we_a, busy_a;
  logic [31:0] cpu_rdata_a, dbg_rdata_a, mem_wdata_a, mem_rdata_a;
  logic [4:0]  mem_addr_a;
  logic        cpu_gnt_b, cpu_rvalid_b, dbg_gnt_b, dbg_rvalid_b, mem_we_b, busy_b;
  logic [31:0] cpu_rdata_b, dbg_rdata_b, mem_wdata_b, mem_rdata_b;
  logic [4:0]  mem_addr_b;

  logic [31:0] ram_a [32];
  logic [31:0] ram_b [32];

  int n_checks = 0;
  int n_fail   = 0;

  dram_arbiter #(.ADDR_W(5), .DATA_W(32), .FILL(FILL), .RR(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_a), .cpu_rdata(cpu_rdata_a), .cpu_rvalid(cpu_rvalid_a),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt_a), .dbg_rdata(dbg_rdata_a), .dbg_rvalid(dbg_rvalid_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .busy(busy_a)
  );

  dram_arbiter #(.ADDR_W(5), .DATA_W(32), .FILL(FILL), .RR(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_b), .cpu_rdata(cpu_rdata_b), .cpu_rvalid(cpu_rvalid_b),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt_b), .dbg_rdata(dbg_rdata_b), .dbg_rvalid(dbg_rvalid_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .busy(busy_b)
  );

  assign mem_rdata_a = ram_a[mem_addr_a];
  assign mem_rdata_b = ram_b[mem_addr_b];
  always @(posedge clk) if (mem_we_a) ram_a[mem_addr_a] <= mem_wdata_a;
  always @(posedge clk) if (mem_we_b) ram_b[mem_addr_b] <= mem_wdata_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic do_reset();
    int guard;
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    guard = 0;
    while (busy_a === 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_timeout: busy=%b required 0", busy_a);
    end
  endtask

  task automatic test_reset();
    int          busy_cycles, bad, guard;
    logic [31:0] exp_rd;
    rst = 1'b1;
    idle();
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd7;
    @(posedge clk); #2;
    n_checks++;
    if ({cpu_gnt_a, dbg_gnt_a, mem_we_a, cpu_rvalid_a, dbg_rvalid_a, busy_a} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: gnt/gnt/we/rv/rv/busy=%b required 000000",
               {cpu_gnt_a, dbg_gnt_a, mem_we_a, cpu_rvalid_a, dbg_rvalid_a, busy_a});
    end
    n_checks++;
    if (cpu_rdata_a !== 32'h0 || dbg_rdata_a !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: cpu=%h dbg=%h required 0", cpu_rdata_a, dbg_rdata_a);
    end
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef DRAM_CLEAR_EN
    busy_cycles = 0; bad = 0; guard = 0;
    @(negedge clk);
    while (busy_a === 1'b1 && guard < 64) begin
      if (mem_we_a !== 1'b1 || mem_addr_a !== busy_cycles[4:0] ||
          mem_wdata_a !== FILL || cpu_gnt_a !== 1'b0) bad++;
      busy_cycles++;
      guard++;
      @(negedge clk);
    end
    n_checks++;
    if (busy_cycles != 32) begin
      n_fail++;
      $display("FAIL sweep_len: busy cycles=%0d required 32", busy_cycles);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL sweep_bus: %0d bad sweep cycles required 0", bad);
    end
    n_checks++;
    if (cpu_gnt_a !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep_first_gnt: cpu_gnt=%b in cycle 33 required 1", cpu_gnt_a);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (ram_a[i] !== FILL) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL sweep_fill: %0d words not FILL required 0", bad);
    end
    exp_rd = FILL;
`else
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0 || cpu_gnt_a !== 1'b1) begin
      n_fail++;
      $display("FAIL first_gnt: busy=%b cpu_gnt=%b required 0 1", busy_a, cpu_gnt_a);
    end
    exp_rd = 32'h0;
`endif
    @(posedge clk); #1;
    cpu_req = 0;
    @(negedge clk);
    n_checks++;
    if (cpu_rvalid_a !== 1'b1 || cpu_rdata_a !== exp_rd) begin
      n_fail++;
      $display("FAIL reset_read7: rvalid=%b rdata=%h required 1 %h", cpu_rvalid_a, cpu_rdata_a, exp_rd);
    end
    @(negedge clk);
    n_checks++;
    if (cpu_rvalid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rvalid_pulse: rvalid=%b required 0", cpu_rvalid_a);
    end
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    idle();
    cpu_req = 1; cpu_we = 1; cpu_addr = 5'd5; cpu_wdata = 32'h12345678;
    @(negedge clk);
    n_checks++;
    if (cpu_gnt_a !== 1'b1 || dbg_gnt_a !== 1'b0 || mem_we_a !== 1'b1 ||
        mem_addr_a !== 5'd5 || mem_wdata_a !== 32'h12345678) begin
      n_fail++;
      $display("FAIL wr_bus: gnt=%b/%b we=%b addr=%0d wdata=%h required 1/0 1 5 12345678",
               cpu_gnt_a, dbg_gnt_a, mem_we_a, mem_addr_a, mem_wdata_a);
    end
    @(posedge clk); #1;
    cpu_we = 0;
    @(negedge clk);
    n_checks++;
    if (cpu_gnt_a !== 1'b1 || mem_we_a !== 1'b0 || cpu_rvalid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_grant: gnt=%b we=%b rvalid=%b required 1 0 0", cpu_gnt_a, mem_we_a, cpu_rvalid_a);
    end
    @(posedge clk); #1;
    cpu_req = 0;
    @(negedge clk);
    n_checks++;
    if (cpu_rvalid_a !== 1'b1 || cpu_rdata_a !== 32'h12345678) begin
      n_fail++;
      $display("FAIL rd_data: rvalid=%b rdata=%h required 1 12345678", cpu_rvalid_a, cpu_rdata_a);
    end
    n_checks++;
    if (mem_we_a !== 1'b0 || mem_addr_a !== 5'd5 || cpu_gnt_a !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: we=%b addr=%0d gnt=%b required 0 5 0", mem_we_a, mem_addr_a, cpu_gnt_a);
    end
    @(negedge clk);
    n_checks++;
    if (cpu_rvalid_a !== 1'b0 || cpu_rdata_a !== 32'h12345678) begin
      n_fail++;
      $display("FAIL rdata_hold: rvalid=%b rdata=%h required 0 12345678", cpu_rvalid_a, cpu_rdata_a);
    end
  endtask

  task automatic test_round_robin();
    logic exp_cpu;
    do_reset();
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd1;
    dbg_req = 1; dbg_we = 0; dbg_addr = 5'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_cpu = (i % 2 == 0);
      n_checks++;
      if (cpu_gnt_a !== exp_cpu || dbg_gnt_a !== !exp_cpu) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: cpu_gnt=%b dbg_gnt=%b required %b %b",
                 i, cpu_gnt_a, dbg_gnt_a, exp_cpu, !exp_cpu);
      end
      @(posedge clk); #1;
    end
    idle();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd3;
    dbg_req = 1; dbg_we = 0; dbg_addr = 5'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (cpu_gnt_b !== 1'b1 || dbg_gnt_b !== 1'b0) begin
        n_fail++;
        $display("FAIL fixed_cycle%0d: cpu_gnt=%b dbg_gnt=%b required 1 0", i, cpu_gnt_b, dbg_gnt_b);
      end
      @(posedge clk); #1;
    end
    cpu_req = 0;
    #1;
    n_checks++;
    if (dbg_gnt_b !== 1'b1 || cpu_gnt_b !== 1'b0) begin
      n_fail++;
      $display("FAIL fixed_handover: cpu_gnt=%b dbg_gnt=%b required 0 1", cpu_gnt_b, dbg_gnt_b);
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_cancel();
    logic [31:0] old9;
    do_reset();
    @(posedge clk); #1;
    old9 = ram_a[9];
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd4;
    dbg_req = 1; dbg_we = 1; dbg_addr = 5'd9; dbg_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if (cpu_gnt_a !== 1'b1 || dbg_gnt_a !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_tie: cpu_gnt=%b dbg_gnt=%b required 1 0", cpu_gnt_a, dbg_gnt_a);
    end
    @(posedge clk); #1;
    idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (dbg_gnt_a !== 1'b0 || dbg_rvalid_a !== 1'b0 || ram_a[9] !== old9) begin
        n_fail++;
        $display("FAIL cancel_%0d: dbg_gnt=%b dbg_rvalid=%b ram9=%h required 0 0 %h",
                 i, dbg_gnt_a, dbg_rvalid_a, ram_a[9], old9);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] old3;
    int          guard;
    @(posedge clk); #1;
    old3 = ram_a[3];
    idle();
    dbg_req = 1; dbg_we = 1; dbg_addr = 5'd3; dbg_wdata = 32'hCAFEF00D;
    #1;
    n_checks++;
    if (dbg_gnt_a !== 1'b1 || mem_we_a !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: dbg_gnt=%b mem_we=%b required 1 1", dbg_gnt_a, mem_we_a);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (dbg_gnt_a !== 1'b0 || mem_we_a !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_drop: dbg_gnt=%b mem_we=%b required 0 0", dbg_gnt_a, mem_we_a);
    end
    @(posedge clk); #1;
    n_checks++;
    if (ram_a[3] !== old3) begin
      n_fail++;
      $display("FAIL areset_nowrite: ram3=%h required %h", ram_a[3], old3);
    end
    idle();
    rst = 1'b0;
    #1;
`ifdef DRAM_CLEAR_EN
    n_checks++;
    if (busy_a !== 1'b1 || mem_addr_a !== 5'd0 || mem_we_a !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_sweep0: busy=%b addr=%0d we=%b required 1 0 1", busy_a, mem_addr_a, mem_we_a);
    end
    guard = 0;
    while (mem_addr_a !== 5'd12 && guard < 40) begin
      @(posedge clk); #2;
      guard++;
    end
    n_checks++;
    if (mem_addr_a !== 5'd12 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep_reach12: addr=%0d busy=%b required 12 1", mem_addr_a, busy_a);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_we_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_areset: we=%b busy=%b required 0 0", mem_we_a, busy_a);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (mem_addr_a !== 5'd0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep_restart: addr=%0d busy=%b required 0 1", mem_addr_a, busy_a);
    end
    guard = 0;
    while (busy_a === 1'b1 && guard < 64) begin
      @(posedge clk); #1;
      guard++;
    end
`else
    guard = 0;
    n_checks++;
    if (busy_a !== 1'b0 || guard != 0) begin
      n_fail++;
      $display("FAIL areset_busy: busy=%b required 0", busy_a);
    end
`endif
  endtask

  // Reference model: one grant per cycle from the req set and who won last;
  // a word array stands in for the RAM contents.
  task automatic test_random();
    logic [31:0] mdl_mem [32];
    logic        last_dbg, exp_cg, exp_dg;
    logic        exp_crv, exp_drv;
    logic [31:0] exp_crd, exp_drd;
    do_reset();
    last_dbg = 1'b1;
    exp_crv = 0; exp_drv = 0; exp_crd = '0; exp_drd = '0;
    exp_cg = 0; exp_dg = 0;
    for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (k < 32) begin
        cpu_req = 1; cpu_we = 1; cpu_addr = k[4:0]; cpu_wdata = $urandom;
        dbg_req = 0;
      end else begin
        if (!cpu_req || exp_cg || $urandom_range(0, 9) == 0) begin
          cpu_req = ($urandom_range(0, 3) != 0); cpu_we = $urandom_range(0, 1) == 1;
          cpu_addr = 5'($urandom); cpu_wdata = $urandom;
        end
        if (!dbg_req || exp_dg || $urandom_range(0, 9) == 0) begin
          dbg_req = ($urandom_range(0, 3) != 0); dbg_we = $urandom_range(0, 1) == 1;
          dbg_addr = 5'($urandom); dbg_wdata = $urandom;
        end
      end
      @(negedge clk);
      n_checks++;
      if (cpu_rvalid_a !== exp_crv || cpu_rdata_a !== exp_crd) begin
        n_fail++;
        $display("FAIL rand_cpu_rd k=%0d: rvalid=%b rdata=%h required %b %h",
                 k, cpu_rvalid_a, cpu_rdata_a, exp_crv, exp_crd);
      end
      n_checks++;
      if (dbg_rvalid_a !== exp_drv || dbg_rdata_a !== exp_drd) begin
        n_fail++;
        $display("FAIL rand_dbg_rd k=%0d: rvalid=%b rdata=%h required %b %h",
                 k, dbg_rvalid_a, dbg_rdata_a, exp_drv, exp_drd);
      end
      exp_cg = cpu_req && (!dbg_req || last_dbg);
      exp_dg = dbg_req && !exp_cg;
      n_checks++;
      if (cpu_gnt_a !== exp_cg || dbg_gnt_a !== exp_dg) begin
        n_fail++;
        $display("FAIL rand_gnt k=%0d: cpu_gnt=%b dbg_gnt=%b required %b %b",
                 k, cpu_gnt_a, dbg_gnt_a, exp_cg, exp_dg);
      end
      n_checks++;
      if (mem_we_a !== ((exp_cg && cpu_we) || (exp_dg && dbg_we))) begin
        n_fail++;
        $display("FAIL rand_we k=%0d: mem_we=%b required %b",
                 k, mem_we_a, (exp_cg && cpu_we) || (exp_dg && dbg_we));
      end
      exp_crv = exp_cg && !cpu_we;
      exp_drv = exp_dg && !dbg_we;
      if (exp_crv) exp_crd = mdl_mem[cpu_addr];
      if (exp_drv) exp_drd = mdl_mem[dbg_addr];
      if (exp_cg && cpu_we) mdl_mem[cpu_addr] = cpu_wdata;
      if (exp_dg && dbg_we) mdl_mem[dbg_addr] = dbg_wdata;
      if (exp_cg)      last_dbg = 1'b0;
      else if (exp_dg) last_dbg = 1'b1;
    end
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      ram_a[i] = '0;
      ram_b[i] = '0;
    end
    test_reset();
    test_write_read();
    test_round_robin();
    test_fixed_priority();
    test_cancel();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
